// File: rtl/hack_cpu_core.sv
// Multi-cycle Hack CPU: A/D/PC registers, req/ack instruction and data ports, Hack ALU.
// Define HACK_CPU_HALT_EN to enable tight-loop halt detection (halted output, HALT state).

module alu (
   input  logic [15:0] i_x,
   input  logic [15:0] i_y,
   input  logic        i_zx,
   input  logic        i_nx,
   input  logic        i_zy,
   input  logic        i_ny,
   input  logic        i_f,
   input  logic        i_no,
   output logic [15:0] o_out,
   output logic        o_zr,
   output logic        o_ng
);
   logic [15:0] w_x;
   logic [15:0] w_y;
   logic [15:0] w_f;

   always_comb begin
      w_x = i_zx ? '0 : i_x;
      if (i_nx) w_x = ~w_x;
      w_y = i_zy ? '0 : i_y;
      if (i_ny) w_y = ~w_y;
      w_f   = i_f ? (w_x + w_y) : (w_x & w_y);
      o_out = i_no ? ~w_f : w_f;
   end

   assign o_zr = (o_out == '0);
   assign o_ng = o_out[15];
endmodule

module hack_cpu_core #(
   parameter logic [14:0] RESET_PC = 15'd0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [14:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [14:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [15:0] dmem_rdata,
   output logic [14:0] pc,
   output logic        halted
);
   typedef enum logic [2:0] {
      S_FETCH,
      S_MREAD,
      S_EXEC,
      S_MWRITE
`ifdef HACK_CPU_HALT_EN
      , S_HALT
`endif
   } state_t;

   state_t      r_state;
   logic [14:0] r_pc;
   logic [15:0] r_a;
   logic [15:0] r_d;
   logic [15:0] r_ir;
   logic [15:0] r_m;
   logic [14:0] r_dmem_addr;
   logic [15:0] r_dmem_wdata;
`ifdef HACK_CPU_HALT_EN
   logic        r_prev_a;
   logic        w_halt;
`endif

   logic [15:0] w_y;
   logic [15:0] w_alu_o;
   logic        w_zr;
   logic        w_ng;
   logic        w_taken;
   logic [14:0] w_pc_inc;

   assign w_y      = r_ir[12] ? r_m : r_a;
   assign w_taken  = (r_ir[2] & w_ng) | (r_ir[1] & w_zr) | (r_ir[0] & ~w_zr & ~w_ng);
   assign w_pc_inc = r_pc + 15'd1;

   alu u_alu (
      .i_x   (r_d),
      .i_y   (w_y),
      .i_zx  (r_ir[11]),
      .i_nx  (r_ir[10]),
      .i_zy  (r_ir[9]),
      .i_ny  (r_ir[8]),
      .i_f   (r_ir[7]),
      .i_no  (r_ir[6]),
      .o_out (w_alu_o),
      .o_zr  (w_zr),
      .o_ng  (w_ng)
   );

`ifdef HACK_CPU_HALT_EN
   assign w_halt = w_taken && (r_a[14:0] == (r_pc - 15'd1)) && r_prev_a;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_FETCH;
         r_pc         <= RESET_PC;
         r_a          <= '0;
         r_d          <= '0;
         r_ir         <= '0;
         r_m          <= '0;
         r_dmem_addr  <= '0;
         r_dmem_wdata <= '0;
`ifdef HACK_CPU_HALT_EN
         r_prev_a     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_FETCH: begin
               if (imem_ack) begin
                  r_ir <= imem_data;
                  if (imem_data[15] && imem_data[12]) begin
                     r_dmem_addr <= r_a[14:0];
                     r_state     <= S_MREAD;
                  end else begin
                     r_state <= S_EXEC;
                  end
               end
            end
            S_MREAD: begin
               if (dmem_ack) begin
                  r_m     <= dmem_rdata;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (!r_ir[15]) begin
                  r_a     <= {1'b0, r_ir[14:0]};
                  r_pc    <= w_pc_inc;
                  r_state <= S_FETCH;
`ifdef HACK_CPU_HALT_EN
                  r_prev_a <= 1'b1;
`endif
               end else begin
                  // jump target and M address use A before this instruction's own write
                  if (r_ir[5]) r_a <= w_alu_o;
                  if (r_ir[4]) r_d <= w_alu_o;
                  r_pc <= w_taken ? r_a[14:0] : w_pc_inc;
                  if (r_ir[3]) begin
                     r_dmem_addr  <= r_a[14:0];
                     r_dmem_wdata <= w_alu_o;
                     r_state      <= S_MWRITE;
                  end else begin
                     r_state <= S_FETCH;
                  end
`ifdef HACK_CPU_HALT_EN
                  r_prev_a <= 1'b0;
                  if (w_halt) r_state <= S_HALT;
`endif
               end
            end
            S_MWRITE: begin
               if (dmem_ack) r_state <= S_FETCH;
            end
`ifdef HACK_CPU_HALT_EN
            S_HALT: r_state <= S_HALT;
`endif
            default: r_state <= S_FETCH;
         endcase
      end
   end

   assign imem_req   = !rst && (r_state == S_FETCH);
   assign dmem_req   = !rst && ((r_state == S_MREAD) || (r_state == S_MWRITE));
   assign dmem_we    = !rst && (r_state == S_MWRITE);
   assign imem_addr  = r_pc;
   assign pc         = r_pc;
   assign dmem_addr  = r_dmem_addr;
   assign dmem_wdata = r_dmem_wdata;
`ifdef HACK_CPU_HALT_EN
   assign halted = (r_state == S_HALT);
`else
   assign halted = 1'b0;
`endif
endmodule

// File: doc/hack_cpu_core.md
Name: hack_cpu_core

Overview:
- Multi-cycle Hack CPU datapath and control wrapped around the existing `alu` block.
- Fetches 16-bit Hack instructions over a req/ack instruction port.
- Holds the A, D and PC registers; decodes A- and C-instructions and drives the ALU control bits (zx nx zy ny f no).
- Performs data-memory reads and writes for M over a req/ack data port, and resolves jumps from the ALU zr/ng flags.

Parameters:
- RESET_PC, 15'd0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  15  fetch address, equals PC.
- imem_ack  in  1  fetch complete; imem_data valid this cycle.
- imem_data  in  16  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = write, 0 = read; valid while dmem_req is high.
- dmem_addr  out  15  data address, equals A[14:0] latched at decode.
- dmem_wdata  out  16  write data.
- dmem_ack  in  1  access complete; dmem_rdata valid on a read.
- dmem_rdata  in  16  read data.
- pc  out  15  current PC.
- halted  out  1  tight-loop halt flag (see Optional Feature).

Behaviour:
- Reset (async, rst=1):
  - state=FETCH; PC=RESET_PC; A=0; D=0; IR=0; M-latch=0.
  - All requests, dmem_we and halted = 0; dmem_addr and dmem_wdata = 0.
  - Outputs reach these values immediately, not at the next edge.
  - After rst deasserts, imem_req rises in the first cycle.
- Reset mid-operation: any outstanding request is abandoned. A late ack arriving while reset is asserted is ignored.
- Handshake:
  - imem_req and dmem_req are decoded from the state register.
  - Address, data and dmem_we are held stable while a request is high.
  - Each request stays high until the matching ack is sampled on a rising edge, then drops the next cycle.
  - An ack in the same cycle the request rises is legal: minimum 1 cycle per access.
  - An ack with no request is ignored.
- States:
  - FETCH: imem_req=1, imem_addr=PC.
    - On imem_ack: IR<=imem_data.
    - If imem_data[15]=1 and imem_data[12]=1, go to MREAD; otherwise go to EXEC.
  - MREAD: dmem_req=1, dmem_we=0, dmem_addr=A. On dmem_ack: M-latch<=dmem_rdata, go to EXEC.
  - EXEC, A-instruction (IR[15]=0): A<={1'b0,IR[14:0]}; PC<=PC+1; go to FETCH.
  - EXEC, C-instruction, ALU drive: x=D; y=IR[12] ? M-latch : A; zx..no=IR[11:6].
  - EXEC, C-instruction, writeback: d1=IR[5] writes A; d2=IR[4] writes D; d3=IR[3] writes M.
  - EXEC, C-instruction, jump: j1..j3=IR[2:0]. Taken = (j1&ng) | (j2&zr) | (j3&~zr&~ng).
  - EXEC, PC update: if taken, PC<=old A[14:0]; else PC<=PC+1.
  - EXEC, M write setup: if d3, latch dmem_addr<=old A[14:0] and dmem_wdata<=ALU o, then go to MWRITE; else go to FETCH.
  - MWRITE: dmem_req=1, dmem_we=1. On dmem_ack, go to FETCH.
  - HALT: only present with the optional feature.
- Old-A rule: jump target and M address always use A as it was before this instruction's own A write. Example: AM=M+1 writes to the old address.
- Simultaneous d1+d2+d3: all three destinations receive the same ALU o.
- C-instructions ignore IR[14:13].
- PC wraps 15'h7FFF -> 0.
- A[15] is only ever set by a C-instruction write.
- Cycle counts (acks immediate):
  - A-instruction or plain C-instruction: 2 cycles.
  - C-instruction with a=1: 3 cycles.
  - C-instruction with d3: +1 cycle.

Optional Feature:
- Macro HACK_CPU_HALT_EN.
- When defined, a one-bit flag records that the previous instruction was an A-instruction. The core enters HALT when all of the following hold in EXEC:
  - jump taken;
  - target == PC-1;
  - the previous instruction was an A-instruction.
- In HALT: halted=1, no requests issued, PC frozen. Only rst exits HALT.
- When undefined: halted is tied 0 and the flag logic is absent.

Test Plan:
- Reset with imem_ack tied 1, program 0x0005 at address 0 -> A=0x0005, PC=1, imem_addr=1 two cycles after reset release.
- Program 0x0005, 0xEC10 (D=A) -> D=0x0005, PC=2, dmem_req never asserted.
- D=5, A=5, then 0xE308 (M=D), dmem_ack delayed 3 cycles -> dmem_req/dmem_we held high for 4 cycles with addr=5 and wdata=0x0005, then a fetch at PC+1.
- A=7, 0xFC10 (D=M), dmem_rdata=0x1234 -> read req at addr 7, then D=0x1234.
- A=10, 0xE301 (D;JGT): with D=5 -> PC=10; with D=0 -> PC+1; with D=0xFFFF -> PC+1. Then 0xEA87 (0;JMP) -> PC=A.
- rst pulsed mid-MWRITE -> dmem_req drops the same cycle, PC=RESET_PC, A=D=0. With HACK_CPU_HALT_EN, program 0x0002 at address 2 followed by 0xEA87 -> halted=1, imem_req stays 0.
